// File: rtl/brc_arbiter.sv
// rtl/brc_arbiter.sv - two-requester round-robin front end for one shared branch comparator
module brc_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_req_valid,
   output logic [1:0]        o_req_ready,
   input  logic [DATA_W-1:0] i_rs1_data_0,
   input  logic [DATA_W-1:0] i_rs2_data_0,
   input  logic              i_br_un_0,
   input  logic [DATA_W-1:0] i_rs1_data_1,
   input  logic [DATA_W-1:0] i_rs2_data_1,
   input  logic              i_br_un_1,
   output logic [1:0]        o_rsp_valid,
   input  logic [1:0]        i_rsp_ready,
   output logic              o_br_less,
   output logic              o_br_equal,
   output logic              o_rsp_id
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t            state;
   logic              rr_ptr;
   logic [1:0]        grant;
   logic              sel_id;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              op_un;
   logic [DATA_W:0]   ext_a;
   logic [DATA_W:0]   ext_b;
   logic              cmp_less;
   logic              cmp_equal;

   // Reset gates the grant so nothing is offered while i_rst_n is low.
   always_comb begin
      grant = 2'b00;
      if (i_rst_n && state == IDLE) begin
         case (i_req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   assign o_req_ready = grant;
   assign sel_id      = grant[1];

   assign op_a  = sel_id ? i_rs1_data_1 : i_rs1_data_0;
   assign op_b  = sel_id ? i_rs2_data_1 : i_rs2_data_0;
   assign op_un = sel_id ? i_br_un_1    : i_br_un_0;

   // One extra bit turns both signednesses into a single signed compare.
   assign ext_a     = {~op_un & op_a[DATA_W-1], op_a};
   assign ext_b     = {~op_un & op_b[DATA_W-1], op_b};
   assign cmp_less  = $signed(ext_a) < $signed(ext_b);
   assign cmp_equal = (op_a == op_b);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         rr_ptr      <= 1'b0;
         o_rsp_valid <= 2'b00;
         o_br_less   <= 1'b0;
         o_br_equal  <= 1'b0;
         o_rsp_id    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  state       <= RESP;
                  rr_ptr      <= ~sel_id;
                  o_rsp_valid <= grant;
                  o_br_less   <= cmp_less;
                  o_br_equal  <= cmp_equal;
                  o_rsp_id    <= sel_id;
               end
            end
            RESP: begin
               if (i_rsp_ready[o_rsp_id]) begin
                  state       <= IDLE;
                  o_rsp_valid <= 2'b00;
               end
            end
            default: begin
               state       <= IDLE;
               o_rsp_valid <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_brc_arbiter.sv
// tb/tb_brc_arbiter.sv - randomized reference-model bench for brc_arbiter
module tb_brc_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] rs1 [2];
   logic [31:0] rs2 [2];
   logic        un  [2];
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic        br_less;
   logic        br_equal;
   logic        rsp_id;

   int checks   = 0;
   int failures = 0;

   // Reference model: one outstanding result plus the preferred requester.
   bit         m_busy;
   bit         m_owner;
   bit         m_less;
   bit         m_equal;
   bit         m_pref;
   logic [1:0] last_grant;

   always #5 clk = ~clk;

   brc_arbiter #(.DATA_W(32)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_rs1_data_0 (rs1[0]),
      .i_rs2_data_0 (rs2[0]),
      .i_br_un_0    (un[0]),
      .i_rs1_data_1 (rs1[1]),
      .i_rs2_data_1 (rs2[1]),
      .i_br_un_1    (un[1]),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_br_less    (br_less),
      .o_br_equal   (br_equal),
      .o_rsp_id     (rsp_id)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_less(input logic [31:0] a, input logic [31:0] b, input bit uns);
      longint va = longint'(a);
      longint vb = longint'(b);
      if (!uns) begin
         if (a[31]) va = va - 64'sh1_0000_0000;
         if (b[31]) vb = vb - 64'sh1_0000_0000;
      end
      return va < vb;
   endfunction

   function automatic logic [1:0] exp_grant();
      if (!rst_n || m_busy) return 2'b00;
      if (req_valid == 2'b11) return m_pref ? 2'b10 : 2'b01;
      return req_valid;
   endfunction

   task automatic m_reset();
      m_busy = 0; m_owner = 0; m_less = 0; m_equal = 0; m_pref = 0;
      last_grant = 2'b00;
   endtask

   task automatic step();
      logic [1:0] g;
      int id;
      @(negedge clk);
      g = exp_grant();
      check("req_ready", 32'(req_ready), 32'(g));
      check("rsp_valid", 32'(rsp_valid), m_busy ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
      if (m_busy) begin
         check("br_less", 32'(br_less), 32'(m_less));
         check("br_equal", 32'(br_equal), 32'(m_equal));
         check("rsp_id", 32'(rsp_id), 32'(m_owner));
      end
      g = exp_grant();
      @(posedge clk);
      if (m_busy) begin
         if (rsp_ready[m_owner]) m_busy = 0;
      end else if (g != 2'b00) begin
         id      = g[1] ? 1 : 0;
         m_busy  = 1;
         m_owner = g[1];
         m_less  = ref_less(rs1[id], rs2[id], un[id]);
         m_equal = (rs1[id] == rs2[id]);
         m_pref  = ~g[1];
      end
      last_grant = g;
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_less"}, 32'(br_less), 32'd0);
      check({tag, "_equal"}, 32'(br_equal), 32'd0);
      check({tag, "_id"}, 32'(rsp_id), 32'd0);
   endtask

   // Assert reset off-edge, check outputs at once, release mid-cycle.
   task automatic do_reset(input string tag);
      req_valid = 2'b11;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs(tag);
      m_reset();
      @(posedge clk);
      #3 rst_n = 1'b1;
      req_valid = 2'b00;
   endtask

   task automatic send1(input int k, input logic [31:0] a, input logic [31:0] b, input bit uns);
      int n = 0;
      rs1[k] = a; rs2[k] = b; un[k] = uns;
      req_valid = (k == 1) ? 2'b10 : 2'b01;
      do begin
         step();
         n++;
      end while (!last_grant[k] && n < 10);
      check("send_granted", 32'(last_grant[k]), 32'd1);
      req_valid = 2'b00;
      step();
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] tbl [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      if ($urandom_range(1) == 0) return $urandom;
      return tbl[$urandom_range(4)];
   endfunction

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      for (int k = 0; k < 2; k++) begin
         rs1[k] = 32'h0; rs2[k] = 32'h0; un[k] = 1'b0;
      end
      m_reset();
      #2 check_reset_outputs("por");
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Equal operands, back-to-back from requester 0.
      rs1[0] = 32'd5; rs2[0] = 32'd5; un[0] = 1'b0;
      req_valid = 2'b01;
      step();
      check("first_grant", 32'(last_grant), 32'd1);
      step();
      step();
      check("regrant_cycle2", 32'(last_grant), 32'd1);
      req_valid = 2'b00;
      step();
      step();

      send1(1, 32'h0000_0000, 32'h8000_0000, 1'b1);
      send1(1, 32'h0000_0000, 32'h8000_0000, 1'b0);
      send1(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      send1(0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
      send1(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

      // Continuous contention after reset alternates 0,1,0,1.
      do_reset("rst_a");
      rs1[0] = 32'd3; rs2[0] = 32'd9; un[0] = 1'b0;
      rs1[1] = 32'd9; rs2[1] = 32'd3; un[1] = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int i = 0; i < 8; i++) step();
      req_valid = 2'b00;
      step();

      // Owner 0 stalls; requester 1's ready must be ignored.
      rs1[0] = 32'd1; rs2[0] = 32'd2;
      req_valid = 2'b01;
      rsp_ready = 2'b10;
      step();
      req_valid = 2'b10;
      for (int i = 0; i < 5; i++) step();
      rsp_ready = 2'b11;
      step();
      step();
      check("bp_grant1", 32'(last_grant), 32'd2);
      req_valid = 2'b00;
      step();

      // Reset in the middle of a response.
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      do_reset("rst_b");
      req_valid = 2'b11;
      step();
      check("post_rst_pri", 32'(last_grant), 32'd1);
      req_valid = 2'b00;
      step();
      step();

      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (req_valid[k] && !last_grant[k]) begin
               if ($urandom_range(7) == 0) req_valid[k] = 1'b0;
            end else begin
               req_valid[k] = 1'($urandom_range(1));
               rs1[k] = pick();
               rs2[k] = ($urandom_range(3) == 0) ? rs1[k] : pick();
               un[k]  = 1'($urandom_range(1));
            end
         end
         rsp_ready = 2'($urandom_range(3));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
